// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder.
// State encoding and default operand width.
package serial_add_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_add_if.sv
// Operand/result handshake bundle.
// master drives operands and accepts results; slave is the adder.
interface serial_add_if
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );

endinterface

// File: rtl/serial_add_ctrl_fa_cell.sv
// Single-bit full adder shared across all bit positions.
// Sum is the 3-input XOR, carry is the majority.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // pure combinational add of one bit column
  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (a & ci) | (b & ci);
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell, LSB first.
// Result regs hold the last completed sum until the next one lands.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic         clk,
  input  logic         rst,
  serial_add_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             fa_s, fa_co;

  fa_cell u_fa (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // next-state, datapath shifting and result capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sr_d    = sr_q;
    res_d   = res_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          sr_d    = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sr_d    = {fa_s, sr_q[WIDTH-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_co;
        if (cnt_q == LAST) begin
          res_d   = {fa_s, sr_q[WIDTH-1:1]};
          cout_d  = fa_co;
          // carry into MSB is the carry reg before this update
          ovf_d   = carry_q ^ fa_co;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers, cleared on async reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sr_q    <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sr_q    <= sr_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // handshake flags decode straight from state
  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.busy      = (state_q == RUN) || (state_q == DONE);
    bus.sum       = res_q;
    bus.cout      = cout_q;
    bus.ovf       = ovf_q;
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (WIDTH=8) and fa_cell.
// Vector table plus backpressure, reset-abort and random sequences.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  serial_add_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic fa_a, fa_b, fa_ci, fa_s, fa_co;

  fa_cell u_fa (
    .a  (fa_a),
    .b  (fa_b),
    .ci (fa_ci),
    .s  (fa_s),
    .co (fa_co)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // one operation: accept, time the latency, hold under backpressure,
  // optionally wiggle in_valid with junk operands while busy
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic tci, input logic [W-1:0] es,
                        input logic ec, input logic eo,
                        input int hold, input bit junk,
                        input string tag);
    int n;
    @(negedge clk);
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.a         = ta;
    bus.b         = tb_;
    bus.cin       = tci;
    bus.out_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk({tag, ".busy"}, 32'(bus.busy), 32'd1);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      if (junk) begin
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.a        = W'($urandom);
        bus.b        = W'($urandom);
      end
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk({tag, ".latency"}, 32'(n), 32'(W));
    chk({tag, ".sum"}, 32'(bus.sum), 32'(es));
    chk({tag, ".cout"}, 32'(bus.cout), 32'(ec));
    chk({tag, ".ovf"}, 32'(bus.ovf), 32'(eo));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      chk({tag, ".hold_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, ".hold_sum"}, 32'(bus.sum), 32'(es));
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".drop"}, 32'(bus.out_valid), 32'd0);
    chk({tag, ".keep"}, 32'({bus.cout, bus.sum}), 32'({ec, es}));
  endtask

  initial begin
    logic [W:0]   full;
    logic [W-1:0] ra, rb, rs;
    logic         rc, ro;

    tbl[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    tbl[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[6] = '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[7] = '{8'h3C, 8'hA5, 1'b1, 8'hE2, 1'b0, 1'b0};

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b1;

    // full-adder cell, all eight input columns
    for (int i = 0; i < 8; i++) begin
      {fa_a, fa_b, fa_ci} = 3'(i);
      #1;
      chk("fa.s", 32'(fa_s), 32'(fa_a ^ fa_b ^ fa_ci));
      chk("fa.co", 32'(fa_co), 32'((32'(fa_a) + fa_b + fa_ci) >= 2));
    end

    #12;
    chk("rst.in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst.sum", 32'({bus.ovf, bus.cout, bus.sum}), 32'd0);
    chk("rst.busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      run_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sum,
             tbl[i].cout, tbl[i].ovf, 0, 1'b0, $sformatf("tbl%0d", i));

    // backpressure; stray in_valid pulses while DONE must be ignored
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a = 8'h55;
    bus.b = 8'hAA;
    bus.cin = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int i = 0; i < W + 1 && !bus.out_valid; i++) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = (i == 5);
      bus.a = 8'h11;
      bus.b = 8'h22;
      chk("bp.valid", 32'(bus.out_valid), 32'd1);
      chk("bp.res", 32'({bus.ovf, bus.cout, bus.sum}), 32'h100);
      if (i == 5) chk("bp.in_ready", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp.release", 32'({bus.out_valid, bus.in_ready}), 32'b01);
    chk("bp.keep", 32'({bus.cout, bus.sum}), 32'h100);

    // async reset three cycles into RUN
    bus.in_valid = 1'b1;
    bus.a = 8'h12;
    bus.b = 8'h34;
    bus.cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst.in_ready", 32'(bus.in_ready), 32'd1);
    chk("arst.sum", 32'(bus.sum), 32'd0);
    chk("arst.busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, 0, 1'b0, "post_rst");

    // random operands, random backpressure, junk in_valid while busy
    for (int k = 0; k < 150; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom_range(0, 1));
      full = (W + 1)'(ra) + (W + 1)'(rb) + (W + 1)'(rc);
      rs = full[W-1:0];
      ro = (ra[W-1] == rb[W-1]) && (rs[W-1] != ra[W-1]);
      run_op(ra, rb, rc, rs, full[W], ro, $urandom_range(0, 3), 1'b1,
             $sformatf("rnd%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial adder controller. It time-shares one single-bit full-adder cell to add two WIDTH-bit operands, one bit per clock, LSB first. Operands enter through a valid/ready input handshake and the result leaves through a valid/ready output handshake. It serves the Basys3 lab designs as an area-minimal alternative to the ripple-carry adder, feeding display and verification logic.

Parameters:
WIDTH, 8, operand and sum width in bits (legal range 2..32)
CNT_W, $clog2(WIDTH), bit-position counter width (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand set presented
in_ready  output  1  controller can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in for bit 0
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
sum  output  WIDTH  A+B+cin, modulo 2^WIDTH
cout  output  1  carry out of MSB
ovf  output  1  two's-complement overflow (carry into MSB XOR carry out of MSB)
busy  output  1  high in RUN or DONE

Behaviour:
- One clock (clk); reset rst is asynchronous and active-high. On rst: state=IDLE, counter=0, all internal regs cleared; outputs in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, busy=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch a and b into shift regs, latch cin into the carry reg, clear sum shift reg, counter=0, go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, feed A[0], B[0] and the carry reg to the full-adder cell.
  - At the edge: shift the sum bit into sum reg MSB (shift right); shift A and B right; carry reg takes the cell's cout.
  - When counter==WIDTH-1, also capture the MSB carry-in (the carry reg before update) for ovf, then go to DONE. Otherwise counter+1.
- DONE:
  - out_valid=1; sum, cout and ovf are held stable.
  - On an edge with out_ready=1, go to IDLE; out_valid drops the next cycle.
  - No timeout; out_valid stays high indefinitely under backpressure.
- Latency: out_valid rises exactly WIDTH clock edges after the accepting edge. Throughput is one operation per WIDTH+2 cycles minimum.
- in_valid while busy is ignored. The operand values are not sampled, and no error is flagged.
- in_ready is combinationally (state==IDLE). out_valid is (state==DONE). Neither depends on the input valid/ready signals, so there are no combinational loops.
- sum, cout and ovf are registered. They hold the last result through IDLE until the next RUN completes; they are undefined only before the first completion (held at 0 after reset).
- Arithmetic: unsigned wrap modulo 2^WIDTH. cout is bit WIDTH of the full sum.
- Reset mid-operation (RUN or DONE): aborts immediately to IDLE with the reset values above, and the partial result is discarded.
- The counter never exceeds WIDTH-1. Unreachable state encodings return to IDLE.

Decomposition:
- Shared package/header (serial_add_pkg):
  - state encoding localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2
  - default WIDTH constant
- One sub-module: fa_cell (1-bit full adder). Ports a, b, ci, s, co; s = a^b^ci; co = majority(a,b,ci).
- One instance lives inside serial_add_ctrl.
- fa_cell gets its own unit test, because XOR inputs must tie to the carry net exactly.

Test Plan:
1. WIDTH=8, a=0x0F, b=0x01, cin=0, out_ready=1 -> sum=0x10, cout=0, ovf=0; out_valid exactly 8 edges after accept, high 1 cycle.
2. a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Then a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0.
3. a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1. Then a=0x80, b=0x80 -> sum=0x00, cout=1, ovf=1.
4. Backpressure: out_ready=0 for 20 cycles after completion of a=0x55, b=0xAA, cin=1 -> out_valid and sum=0x00, cout=1 stable throughout. A second in_valid pulse during this window is ignored (in_ready=0). Release out_ready -> IDLE next cycle.
5. Reset mid-op: accept a=0x12, b=0x34, assert rst async after 3 RUN cycles -> immediately out_valid=0, in_ready=1, sum=0, busy=0. The next op a=0x01, b=0x02 -> sum=0x03.
6. Random regression, 1000 ops, random in_valid/out_ready toggling, WIDTH in {2,8,32} -> every result matches {cout,sum}=a+b+cin, ovf matches the signed-overflow model, no operation lost or duplicated.
